// File: rtl/mp_modaddsub.sv
// ---------------------------------------------------------------------------
// mp_modaddsub
// Word-serial multi-precision modular adder/subtractor.
//
// Computes (in_a + in_b) mod in_m or (in_a - in_b) mod in_m with a single
// WORD-bit carry chain that is reused over NWORDS cycles per pass.
// Operands are zero-extended to NWORDS*WORD bits inside the block.
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous, active-high reset
//   start     request pulse, only sampled while idle
//   subtract  0 = add, 1 = subtract (captured together with start)
//   in_a      operand A (expected < in_m)
//   in_b      operand B (expected < in_m)
//   in_m      modulus   (expected > 0)
//   result    modular result, stable from done until the next accepted start
//   done      one-cycle completion pulse
//   busy      high from the cycle after acceptance until done
//
// Flow: IDLE -> PASS1 (s = a +/- b) -> PASS2 (t = s -/+ m) -> FIN -> IDLE.
// Latency is fixed at 2*NWORDS+1 clock edges after the accepting edge.
// ---------------------------------------------------------------------------
module mp_modaddsub #(
  parameter int WIDTH = 1027,
  parameter int WORD  = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             subtract,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy
);

  localparam int NWORDS = (WIDTH + WORD - 1) / WORD;
  localparam int PW     = NWORDS * WORD;
  localparam int IDXW   = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS1 = 2'd1,
    PASS2 = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t            state_q;
  logic [IDXW-1:0]   idx_q;
  logic              carry_q;
  logic              c1_q;
  logic              c2_q;
  logic              sub_q;
  // a_q holds A during PASS1; once A has been shifted out it collects t
  // during PASS2, so no separate t register is needed.
  logic [PW-1:0]     a_q;
  logic [PW-1:0]     b_q;
  logic [PW-1:0]     m_q;
  logic [PW-1:0]     s_q;
  logic [WIDTH-1:0]  result_q;
  logic              done_q;
  logic              busy_q;

  logic [WORD-1:0]   op_x;
  logic [WORD-1:0]   op_y;
  logic              op_cin;
  logic [WORD:0]     sum_full;
  logic [WORD-1:0]   sum_word;
  logic              carry_out;
  logic              idx_last;
  logic [PW-1:0]     a_shift_in;   // sum word shifted into a_q from the top
  logic [PW-1:0]     s_shift_in;   // sum word shifted into s_q from the top
  logic [PW-1:0]     s_rotate;     // s_q rotated right by one word
  logic              sel_t;

  // Shared word-wide carry chain and the shift/rotate helpers around it.
  always_comb begin
    op_x   = {WORD{1'b0}};
    op_y   = {WORD{1'b0}};
    op_cin = 1'b0;
    case (state_q)
      PASS1: begin
        // subtract: a + ~b + 1, injected as carry-in on the first word
        op_x   = a_q[WORD-1:0];
        op_y   = sub_q ? ~b_q[WORD-1:0] : b_q[WORD-1:0];
        op_cin = (idx_q == {IDXW{1'b0}}) ? sub_q : carry_q;
      end
      PASS2: begin
        // add: s + ~m + 1 ; subtract: s + m
        op_x   = s_q[WORD-1:0];
        op_y   = sub_q ? m_q[WORD-1:0] : ~m_q[WORD-1:0];
        op_cin = (idx_q == {IDXW{1'b0}}) ? ~sub_q : carry_q;
      end
      default: begin
        op_x   = {WORD{1'b0}};
        op_y   = {WORD{1'b0}};
        op_cin = 1'b0;
      end
    endcase
    sum_full   = {1'b0, op_x} + {1'b0, op_y} + {{WORD{1'b0}}, op_cin};
    sum_word   = sum_full[WORD-1:0];
    carry_out  = sum_full[WORD];
    idx_last   = (idx_q == IDXW'(NWORDS - 1));
    a_shift_in = PW'({sum_word, a_q} >> WORD);
    s_shift_in = PW'({sum_word, s_q} >> WORD);
    s_rotate   = PW'({s_q[WORD-1:0], s_q} >> WORD);
    // add: s >= m exactly when a carry appeared in either pass
    // subtract: c1 = 0 means a borrow, so the modulus must be added back
    if (sub_q) begin
      sel_t = ~c1_q;
    end else begin
      sel_t = c1_q | c2_q;
    end
  end

  // Control FSM, operand shift registers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= {IDXW{1'b0}};
      carry_q  <= 1'b0;
      c1_q     <= 1'b0;
      c2_q     <= 1'b0;
      sub_q    <= 1'b0;
      a_q      <= {PW{1'b0}};
      b_q      <= {PW{1'b0}};
      m_q      <= {PW{1'b0}};
      s_q      <= {PW{1'b0}};
      result_q <= {WIDTH{1'b0}};
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= PW'(in_a);
            b_q     <= PW'(in_b);
            m_q     <= PW'(in_m);
            sub_q   <= subtract;
            idx_q   <= {IDXW{1'b0}};
            carry_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= PASS1;
          end
        end
        PASS1: begin
          a_q     <= a_q >> WORD;
          b_q     <= b_q >> WORD;
          s_q     <= s_shift_in;
          carry_q <= carry_out;
          if (idx_last) begin
            c1_q    <= carry_out;
            idx_q   <= {IDXW{1'b0}};
            state_q <= PASS2;
          end else begin
            idx_q <= idx_q + {{(IDXW-1){1'b0}}, 1'b1};
          end
        end
        PASS2: begin
          // s is rotated so it is back in place for the FIN selection
          s_q     <= s_rotate;
          a_q     <= a_shift_in;
          m_q     <= m_q >> WORD;
          carry_q <= carry_out;
          if (idx_last) begin
            c2_q    <= carry_out;
            idx_q   <= {IDXW{1'b0}};
            state_q <= FIN;
          end else begin
            idx_q <= idx_q + {{(IDXW-1){1'b0}}, 1'b1};
          end
        end
        FIN: begin
          result_q <= sel_t ? a_q[WIDTH-1:0] : s_q[WIDTH-1:0];
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign result = result_q;
  assign done   = done_q;
  assign busy   = busy_q;

endmodule
